// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock FIFO with any depth >= 2, an occupancy count,
// almost-full/almost-empty thresholds and either a registered read or a
// first-word-fall-through read.
// Build option: define FIFO_ERR_FLAGS_EN to get sticky overflow/underflow
// flags cleared by clr_err. Without it, both flags read 0 and clr_err is ignored.
module fifo_flagged #(
  parameter int WIDTH               = 8,
  parameter int DEPTH               = 16,
  parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2,
  parameter int FWFT                = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  output logic                       full,
  output logic                       almost_full,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Reject configurations the flag decode cannot represent.
  generate
    if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "fifo_flagged: WIDTH must be >= 1");
    end
    if (DEPTH < 2) begin : g_bad_depth
      $fatal(1, "fifo_flagged: DEPTH must be >= 2");
    end
    if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_af
      $fatal(1, "fifo_flagged: ALMOST_FULL_THRESH out of range 1..DEPTH");
    end
    if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > DEPTH - 1) begin : g_bad_ae
      $fatal(1, "fifo_flagged: ALMOST_EMPTY_THRESH out of range 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $fatal(1, "fifo_flagged: FWFT must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             valid_wr, valid_rd;

  // Pointers wrap by explicit compare so DEPTH need not be a power of 2.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  // Requests are qualified against the registered flags. A write while full
  // is dropped even if a read frees a slot on the same edge.
  assign valid_wr = wr_en && !full;
  assign valid_rd = rd_en && !empty;

  // Status flags decode straight from the registered count.
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(ALMOST_FULL_THRESH));
  assign almost_empty = (count <= CW'(ALMOST_EMPTY_THRESH));

  // Storage write. No reset: contents are only visible through valid pointers.
  always_ff @(posedge clk) begin
    if (valid_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (valid_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (valid_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({valid_wr, valid_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is shown directly; forced to 0 while empty so the output
      // is defined out of reset. A new write only becomes visible after its
      // edge, so there is no same-cycle path from wr_data.
      assign rd_data = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [WIDTH-1:0] rd_q;
      // Registered read: capture the head on a valid pop, otherwise hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        rd_q <= '0;
        else if (valid_rd) rd_q <= mem[rd_ptr];
      end
      assign rd_data = rd_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags: a new error on the same edge as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_err)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: three instances (depth 16 registered, depth 5
// registered, depth 7 FWFT) share one stimulus stream. A queue model per
// instance is checked on every falling edge, and directed phases pin
// literal values.
module tb_fifo_flagged;
  localparam int NI = 3;
  localparam int DEP [NI] = '{16, 5, 7};
  localparam int AFT [NI] = '{14, 3, 5};
  localparam int AET [NI] = '{2, 2, 1};
  localparam int FWM [NI] = '{0, 0, 1};
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       full_a [NI], afull_a [NI], empty_a [NI], aempty_a [NI];
  logic       ovf_a [NI], unf_a [NI];
  logic [7:0] rdd_a [NI];
  logic [4:0] cnt0;
  logic [2:0] cnt1, cnt2;
  logic [31:0] cnt_a [NI];

  assign cnt_a[0] = 32'(cnt0);
  assign cnt_a[1] = 32'(cnt1);
  assign cnt_a[2] = 32'(cnt2);

  always #5 clk = ~clk;

  fifo_flagged #(.WIDTH(8), .DEPTH(16), .ALMOST_FULL_THRESH(14), .ALMOST_EMPTY_THRESH(2), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full_a[0]),
    .almost_full(afull_a[0]), .rd_en(rd_en), .rd_data(rdd_a[0]), .empty(empty_a[0]),
    .almost_empty(aempty_a[0]), .count(cnt0), .clr_err(clr_err),
    .overflow(ovf_a[0]), .underflow(unf_a[0]));

  fifo_flagged #(.WIDTH(8), .DEPTH(5), .ALMOST_FULL_THRESH(3), .ALMOST_EMPTY_THRESH(2), .FWFT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full_a[1]),
    .almost_full(afull_a[1]), .rd_en(rd_en), .rd_data(rdd_a[1]), .empty(empty_a[1]),
    .almost_empty(aempty_a[1]), .count(cnt1), .clr_err(clr_err),
    .overflow(ovf_a[1]), .underflow(unf_a[1]));

  fifo_flagged #(.WIDTH(8), .DEPTH(7), .ALMOST_FULL_THRESH(5), .ALMOST_EMPTY_THRESH(1), .FWFT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full_a[2]),
    .almost_full(afull_a[2]), .rd_en(rd_en), .rd_data(rdd_a[2]), .empty(empty_a[2]),
    .almost_empty(aempty_a[2]), .count(cnt2), .clr_err(clr_err),
    .overflow(ovf_a[2]), .underflow(unf_a[2]));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a queue; registered read data is the last popped entry.
  bit [7:0] mq [NI][$];
  bit [7:0] mrd [NI];
  bit       movf [NI], munf [NI];

  always begin
    @(posedge clk or negedge rst_n);
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        mrd[i]  = 8'h00;
        movf[i] = 1'b0;
        munf[i] = 1'b0;
      end else begin
        int  n;
        bit  f, e;
        bit [7:0] h;
        n = mq[i].size();
        f = (n == DEP[i]);
        e = (n == 0);
        if (wr_en && f)   movf[i] = 1'b1;
        else if (clr_err) movf[i] = 1'b0;
        if (rd_en && e)   munf[i] = 1'b1;
        else if (clr_err) munf[i] = 1'b0;
        if (rd_en && !e) begin
          h = mq[i].pop_front();
          if (FWM[i] == 0) mrd[i] = h;
        end
        if (wr_en && !f) mq[i].push_back(wr_data);
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always begin
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int n;
      n = mq[i].size();
      chk($sformatf("u%0d.count", i), cnt_a[i], 32'(n));
      chk($sformatf("u%0d.full", i), 32'(full_a[i]), 32'(n == DEP[i]));
      chk($sformatf("u%0d.empty", i), 32'(empty_a[i]), 32'(n == 0));
      chk($sformatf("u%0d.almost_full", i), 32'(afull_a[i]), 32'(n >= AFT[i]));
      chk($sformatf("u%0d.almost_empty", i), 32'(aempty_a[i]), 32'(n <= AET[i]));
      if (FWM[i] != 0) begin
        if (n > 0) chk($sformatf("u%0d.rd_data_fwft", i), 32'(rdd_a[i]), 32'(mq[i][0]));
      end else begin
        chk($sformatf("u%0d.rd_data", i), 32'(rdd_a[i]), 32'(mrd[i]));
      end
      chk($sformatf("u%0d.overflow", i), 32'(ovf_a[i]), 32'(FLAGS && movf[i]));
      chk($sformatf("u%0d.underflow", i), 32'(unf_a[i]), 32'(FLAGS && munf[i]));
    end
  end

  // Apply one cycle of inputs; returns at the falling edge after the capturing edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic re, input logic ce);
    wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp5 [5];
    int wb, rb;
    exp5 = '{8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst.count", 32'(cnt0), 32'd0);
    chk("rst.empty", 32'(empty_a[0]), 32'd1);
    chk("rst.full", 32'(full_a[0]), 32'd0);
    chk("rst.almost_empty", 32'(aempty_a[0]), 32'd1);
    chk("rst.almost_full", 32'(afull_a[0]), 32'd0);
    chk("rst.rd_data", 32'(rdd_a[0]), 32'd0);
    chk("rst.overflow", 32'(ovf_a[0]), 32'd0);
    chk("rst.underflow", 32'(unf_a[0]), 32'd0);
    rst_n = 1'b1;

    // Fill depth-16 with 0x01..0x10, then read back in order
    for (int k = 1; k <= 16; k++) step(1'b1, 8'(k), 1'b0, 1'b0);
    chk("fill16.full", 32'(full_a[0]), 32'd1);
    chk("fill16.count", 32'(cnt0), 32'd16);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain16.rd_data", 32'(rdd_a[0]), 32'(k));
    end
    chk("drain16.empty", 32'(empty_a[0]), 32'd1);
    chk("drain16.count", 32'(cnt0), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Depth-5 wrap: A,B,C in, two out, D..G in, expect C..G out
    step(1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h0D + k), 1'b0, 1'b0);
    chk("wrap5.full", 32'(full_a[1]), 32'd1);
    chk("wrap5.count", 32'(cnt1), 32'd5);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("wrap5.rd_data", 32'(rdd_a[1]), 32'(exp5[k]));
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Threshold edges on depth-16 (AF=14, AE=2)
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
      chk("thr.almost_empty", 32'(aempty_a[0]), 32'(k <= 2));
      chk("thr.almost_full", 32'(afull_a[0]), 32'(k >= 14));
    end

    // Full with simultaneous write+read: write dropped, read taken
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("fullrw.count", 32'(cnt0), 32'd15);
    chk("fullrw.overflow", 32'(ovf_a[0]), 32'(FLAGS));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fullrw.overflow_hold", 32'(ovf_a[0]), 32'(FLAGS));
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fullrw.overflow_clr", 32'(ovf_a[0]), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("fullrw.rd_data", 32'(rdd_a[0]), 32'(8'h21 + k));
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // FWFT: write to empty is visible next cycle without rd_en
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("fwft.empty", 32'(empty_a[2]), 32'd0);
    chk("fwft.rd_data", 32'(rdd_a[2]), 32'h0AA);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fwft.rd_data_hold", 32'(rdd_a[2]), 32'h0AA);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft.pop_empty", 32'(empty_a[2]), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft.uf_count", 32'(cnt2), 32'd0);
    chk("fwft.underflow", 32'(unf_a[2]), 32'(FLAGS));

    // Asynchronous reset mid-burst at count 7
    for (int k = 0; k < 7; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    chk("arst.pre_count", 32'(cnt0), 32'd7);
    wr_en = 1'b1; wr_data = 8'h47;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.count", 32'(cnt0), 32'd0);
    chk("arst.empty", 32'(empty_a[0]), 32'd1);
    chk("arst.overflow", 32'(ovf_a[2]), 32'd0);
    chk("arst.underflow", 32'(unf_a[2]), 32'd0);
    wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("arst.new_data", 32'(rdd_a[0]), 32'h055);
    chk("arst.new_count", 32'(cnt0), 32'd0);

    // Random traffic with phases biased toward filling and draining
    for (int c = 0; c < 3000; c++) begin
      if ((c / 200) % 2 == 0) begin wb = 70; rb = 30; end
      else                    begin wb = 30; rb = 70; end
      step(32'($urandom_range(0, 99)) < 32'(wb), 8'($urandom),
           32'($urandom_range(0, 99)) < 32'(rb), $urandom_range(0, 99) < 3);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_flagged.md
Name: fifo_flagged

Overview:
Parametrised synchronous FIFO, next generation of the team's single-clock FIFO. Adds:
- arbitrary (non-power-of-2) depth
- occupancy count
- programmable almost-full and almost-empty thresholds
- selectable standard or first-word-fall-through (FWFT) read mode
- optional sticky overflow/underflow error flags

Used as the general buffering element between streaming producer/consumer blocks.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be power of 2)
ALMOST_FULL_THRESH, DEPTH-2, almost_full asserts when count >= this value (1..DEPTH)
ALMOST_EMPTY_THRESH, 2, almost_empty asserts when count <= this value (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_data  in  WIDTH  write data
full  out  1  count == DEPTH
almost_full  out  1  count >= ALMOST_FULL_THRESH
rd_en  in  1  read request (FWFT: pop/acknowledge of head)
rd_data  out  WIDTH  read data
empty  out  1  count == 0
almost_empty  out  1  count <= ALMOST_EMPTY_THRESH
count  out  $clog2(DEPTH+1)  current occupancy
clr_err  in  1  synchronous clear of error flags
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (rst_n); clock port named clk.
- Reset (rst_n=0, asserts immediately, independent of clk):
  - pointers and count = 0; empty=1, full=0, almost_empty=1, almost_full=0
  - rd_data=0, overflow=0, underflow=0
  - storage contents need not be cleared
- Reset mid-operation discards all entries. Deassertion is sampled synchronously; the first write is accepted on the first rising edge with rst_n=1.
- Qualified operations:
  - valid_wr = wr_en && !full
  - valid_rd = rd_en && !empty
  - invalid requests are ignored and leave state and storage unchanged
  - a write while full is dropped even if a valid read occurs in the same cycle
- Pointers: wr_ptr/rd_ptr range 0..DEPTH-1 and wrap from DEPTH-1 to 0 (explicit compare, no power-of-2 reliance).
- Count update:
  - +1 on valid_wr only; -1 on valid_rd only
  - unchanged on both or neither
  - full, empty, almost_full and almost_empty are all decoded combinationally from the registered count
- Standard mode (FWFT=0):
  - on valid_rd, rd_data is registered with the head entry and valid the cycle after rd_en
  - rd_data holds its value when no valid read occurs
- FWFT mode (FWFT=1):
  - rd_data shows the head entry combinationally whenever empty=0; rd_en pops it
  - when empty=1, rd_data is don't-care
  - a write to an empty FIFO makes the data visible and empty=0 on the cycle after the write edge
  - no same-cycle bypass of wr_data
- Simultaneous valid_rd and valid_wr:
  - when empty: write accepted, read rejected
  - when full: read accepted, write rejected
- Thresholds are static parameters; elaboration fails via $fatal if they are out of range.

Optional Feature:
FIFO_ERR_FLAGS_EN
- Defined:
  - overflow sets on the edge where wr_en && full; underflow sets on the edge where rd_en && empty
  - both remain set until clr_err=1 (synchronous clear) or reset
  - if clr_err and a new error occur in the same cycle, the set wins
- Not defined: overflow and underflow are tied to 0, clr_err is ignored, and no flag registers exist. Ports stay present in both builds.

Test Plan:
- Reset, then DEPTH=16, WIDTH=8, FWFT=0: write 0x01..0x10 on 16 cycles, then read 16 -> full=1 after 16th write edge; count=16; rd_data sequence 0x01..0x10 one cycle after each rd_en; empty=1 and count=0 at end.
- DEPTH=5 (non-power-of-2): 3 writes (A,B,C), 2 reads, then 4 writes (D..G) -> wrap correct, full=1, reads return C,D,E,F,G in order.
- Thresholds AF=14, AE=2: fill one entry at a time -> almost_empty=1 for count 0..2, drops at count 3; almost_full rises at count=14 and stays through 16.
- Full FIFO, wr_en=1 and rd_en=1 for one cycle -> count stays 16 then becomes 15; the dropped write data never appears. With FIFO_ERR_FLAGS_EN: overflow=1 and stays 1 until clr_err pulse, then 0.
- FWFT=1: write 0xAA to empty FIFO -> next cycle empty=0, rd_data=0xAA with no rd_en; rd_en pulse -> empty=1. A read while empty sets underflow (with macro) and leaves count 0.
- Assert rst_n=0 asynchronously mid-burst with count=7 -> empty=1, count=0, flags cleared before the next clk edge; post-reset write/read returns only the new data.
